// File: rtl/rpc_pad_dir_ctrl.sv
// rtl/rpc_pad_dir_ctrl.sv - RPC DRAM pad direction/turnaround sequencer for DQS/DQSN and DB[15:0]
// Optional read idle timeout: define RPC_PAD_DIR_TIMEOUT_EN.
module rpc_pad_dir_ctrl #(
  parameter int PRE_CYCLES  = 2,
  parameter int POST_CYCLES = 1,
  parameter int TURN_CYCLES = 2,
  parameter int LEN_W       = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_write_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic             wbeat_ready_o,
  input  logic             rbeat_valid_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             timeout_o,
  output logic             oe_dqs_o,
  output logic             oe_db_o,
  output logic             ie_dqs_o,
  output logic             ie_db_o,
  output logic             pd_en_dqs_o,
  output logic             pd_en_db_o
);

  // One shared phase/beat counter; wide enough for a full-length burst and every phase length.
  localparam int CW = (LEN_W > 16) ? LEN_W : 16;

  if (PRE_CYCLES < 1 || POST_CYCLES < 1 || TURN_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
    $error("rpc_pad_dir_ctrl: cycle parameters must be >= 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_PRE,
    WR_DATA,
    WR_POST,
    RD_DATA,
    TURN
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [LEN_W-1:0] len_q, len_n;

`ifdef RPC_PAD_DIR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt, idle_n;
  logic          to_q, to_n;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
`ifdef RPC_PAD_DIR_TIMEOUT_EN
      idle_cnt <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      len_q <= len_n;
`ifdef RPC_PAD_DIR_TIMEOUT_EN
      idle_cnt <= idle_n;
      to_q     <= to_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len_q;
`ifdef RPC_PAD_DIR_TIMEOUT_EN
    idle_n  = idle_cnt;
    to_n    = to_q;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
`ifdef RPC_PAD_DIR_TIMEOUT_EN
        idle_n = '0;
        to_n   = 1'b0;
`endif
        if (req_valid_i) begin
          len_n   = req_len_i;
          state_n = req_write_i ? WR_PRE : RD_DATA;
        end
      end
      WR_PRE: begin
        if (cnt == CW'(PRE_CYCLES - 1)) begin
          state_n = WR_DATA;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      WR_DATA: begin
        if (cnt == CW'(len_q)) begin
          state_n = WR_POST;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      WR_POST: begin
        if (cnt == CW'(POST_CYCLES - 1)) begin
          state_n = TURN;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      RD_DATA: begin
        // cnt holds beats already captured, so it tops out at len and never wraps
        if (rbeat_valid_i) begin
`ifdef RPC_PAD_DIR_TIMEOUT_EN
          idle_n = '0;
`endif
          if (cnt == CW'(len_q)) begin
            state_n = TURN;
            cnt_n   = '0;
          end else cnt_n = cnt + 1'b1;
        end
`ifdef RPC_PAD_DIR_TIMEOUT_EN
        else if (idle_cnt == TW'(TIMEOUT - 1)) begin
          state_n = TURN;
          cnt_n   = '0;
          to_n    = 1'b1;
        end else idle_n = idle_cnt + 1'b1;
`endif
      end
      TURN: begin
        if (cnt == CW'(TURN_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else cnt_n = cnt + 1'b1;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    req_ready_o   = 1'b0;
    wbeat_ready_o = 1'b0;
    busy_o        = (state != IDLE);
    done_o        = 1'b0;
    oe_dqs_o      = 1'b0;
    oe_db_o       = 1'b0;
    ie_dqs_o      = 1'b0;
    ie_db_o       = 1'b0;
    pd_en_dqs_o   = 1'b1;
    pd_en_db_o    = 1'b1;
    case (state)
      IDLE:    req_ready_o = ~rst_i;
      WR_PRE: begin
        oe_dqs_o    = 1'b1;
        oe_db_o     = 1'b1;
        pd_en_dqs_o = 1'b0;
        pd_en_db_o  = 1'b0;
      end
      WR_DATA: begin
        oe_dqs_o      = 1'b1;
        oe_db_o       = 1'b1;
        wbeat_ready_o = 1'b1;
        pd_en_dqs_o   = 1'b0;
        pd_en_db_o    = 1'b0;
      end
      WR_POST: begin
        oe_dqs_o    = 1'b1;
        pd_en_dqs_o = 1'b0;
      end
      RD_DATA: begin
        ie_dqs_o    = 1'b1;
        ie_db_o     = 1'b1;
        pd_en_dqs_o = 1'b0;
        pd_en_db_o  = 1'b0;
      end
      TURN:    done_o = (cnt == CW'(TURN_CYCLES - 1));
      default: ;
    endcase
`ifdef RPC_PAD_DIR_TIMEOUT_EN
    timeout_o = done_o & to_q;
`else
    timeout_o = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rpc_pad_dir_ctrl.sv
// tb/tb_rpc_pad_dir_ctrl.sv - self-checking bench for rpc_pad_dir_ctrl (default build)
module tb_rpc_pad_dir_ctrl;

  localparam int PRE  = 2;
  localparam int POST = 1;
  localparam int TURN = 2;

  logic       clk = 1'b0;
  logic       rst_i, req_valid_i, req_write_i, rbeat_valid_i;
  logic [7:0] req_len_i;
  logic       req_ready_o, wbeat_ready_o, busy_o, done_o, timeout_o;
  logic       oe_dqs_o, oe_db_o, ie_dqs_o, ie_db_o, pd_en_dqs_o, pd_en_db_o;

  always #5 clk = ~clk;

  rpc_pad_dir_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_write_i(req_write_i), .req_len_i(req_len_i),
    .wbeat_ready_o(wbeat_ready_o), .rbeat_valid_i(rbeat_valid_i),
    .busy_o(busy_o), .done_o(done_o), .timeout_o(timeout_o),
    .oe_dqs_o(oe_dqs_o), .oe_db_o(oe_db_o), .ie_dqs_o(ie_dqs_o), .ie_db_o(ie_db_o),
    .pd_en_dqs_o(pd_en_dqs_o), .pd_en_db_o(pd_en_db_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference: a burst is "t cycles since acceptance"; phase boundaries come from arithmetic.
  bit m_busy, m_wr;
  int m_len, m_t, m_beats, m_end;
  int low_run = 0;
  bit prev_drive = 1'b0, seen_drive = 1'b0;

  function automatic logic [10:0] model_out();
    logic rdy, wb, bz, dn, oq, ob, iq, ib, pq, pb;
    int d, p, t_last;
    rdy = 0; wb = 0; bz = 0; dn = 0; oq = 0; ob = 0; iq = 0; ib = 0; pq = 1; pb = 1;
    if (!m_busy) rdy = ~rst_i;
    else begin
      bz = 1;
      if (m_wr) begin
        d = PRE + m_len + 1;
        p = d + POST;
        t_last = p + TURN;
        if (m_t <= PRE) begin oq = 1; ob = 1; pq = 0; pb = 0; end
        else if (m_t <= d) begin oq = 1; ob = 1; wb = 1; pq = 0; pb = 0; end
        else if (m_t <= p) begin oq = 1; pq = 0; end
        else dn = (m_t == t_last);
      end else begin
        if (m_end == 0) begin iq = 1; ib = 1; pq = 0; pb = 0; end
        else dn = (m_t == m_end + TURN - 1);
      end
    end
    return {rdy, wb, bz, dn, 1'b0, oq, ob, iq, ib, pq, pb};
  endfunction

  task automatic model_step();
    logic [10:0] cur;
    cur = model_out();
    if (rst_i) m_busy = 0;
    else if (!m_busy) begin
      if (req_valid_i) begin
        m_busy = 1; m_wr = req_write_i; m_len = int'(req_len_i);
        m_t = 1; m_beats = 0; m_end = 0;
      end
    end else if (cur[7]) m_busy = 0;
    else begin
      if (!m_wr && m_end == 0 && rbeat_valid_i) begin
        m_beats++;
        if (m_beats == m_len + 1) m_end = m_t + 1;
      end
      m_t++;
    end
  endtask

  task automatic expect_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic check(input string tag);
    logic [10:0] exp, act;
    logic drive;
    exp = model_out();
    act = {req_ready_o, wbeat_ready_o, busy_o, done_o, timeout_o,
           oe_dqs_o, oe_db_o, ie_dqs_o, ie_db_o, pd_en_dqs_o, pd_en_db_o};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d outputs got=%b want=%b", tag, cyc, act, exp);
    end
    drive = oe_dqs_o | oe_db_o | ie_dqs_o | ie_db_o;
    if (drive && !prev_drive && seen_drive) expect_int({tag, "_turn_gap"}, (low_run >= TURN) ? 1 : 0, 1);
    if (drive) seen_drive = 1'b1;
    low_run = drive ? 0 : low_run + 1;
    prev_drive = drive;
  endtask

  task automatic step(input bit r, input bit v, input bit w, input int l, input bit b, input string tag);
    rst_i = r; req_valid_i = v; req_write_i = w; req_len_i = l[7:0]; rbeat_valid_i = b;
    model_step();
    if (r) seen_drive = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check(tag);
  endtask

  typedef struct {
    bit wr;
    int len;
    int gap;
    int exp_done;
    int exp_wbeats;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int k, done_at, nwb, d1, d2, n_done;
    m_busy = 0; m_wr = 0; m_len = 0; m_t = 0; m_beats = 0; m_end = 0;

    vecs[0] = '{1'b1, 3,   1, 9,   4};
    vecs[1] = '{1'b1, 0,   1, 6,   1};
    vecs[2] = '{1'b1, 255, 1, 261, 256};
    vecs[3] = '{1'b0, 1,   2, 6,   0};
    vecs[4] = '{1'b0, 0,   1, 3,   0};
    vecs[5] = '{1'b0, 3,   3, 14,  0};
    vecs[6] = '{1'b0, 255, 1, 258, 0};

    // reset state
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, "reset");
    expect_int("reset_ready_low", int'(req_ready_o), 0);
    expect_int("reset_pd_dqs", int'(pd_en_dqs_o), 1);
    step(0, 0, 0, 0, 0, "reset_release");
    expect_int("reset_ready_high", int'(req_ready_o), 1);

    // table-driven bursts: done latency and write beat count
    foreach (vecs[i]) begin
      step(0, 1, vecs[i].wr, vecs[i].len, 0, "vec");
      k = 1; done_at = -1; nwb = 0;
      while (done_at < 0 && k < 700) begin
        if (wbeat_ready_o) nwb++;
        if (done_o) done_at = k;
        else begin
          step(0, 0, 0, 0, !vecs[i].wr && (k % vecs[i].gap == 0), "vec");
          k++;
        end
      end
      expect_int($sformatf("vec%0d_done_cycle", i), done_at, vecs[i].exp_done);
      expect_int($sformatf("vec%0d_wbeats", i), nwb, vecs[i].exp_wbeats);
      step(0, 0, 0, 0, 0, "vec_idle");
      expect_int($sformatf("vec%0d_idle_ready", i), int'(req_ready_o), 1);
    end

    // read len=1 with beats at cycles 4 and 6
    step(0, 1, 0, 1, 0, "rd_len1");
    expect_int("rd_len1_ie_rise", int'(ie_db_o), 1);
    done_at = -1;
    for (int c = 1; c < 12; c++) begin
      if (c == 7) expect_int("rd_len1_ie_low_at_7", int'(ie_dqs_o | ie_db_o), 0);
      if (done_o && done_at < 0) done_at = c;
      step(0, 0, 0, 0, (c == 4 || c == 6), "rd_len1");
    end
    expect_int("rd_len1_done_cycle", done_at, 8);

    // extra read beats while idle do nothing
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, "idle_rbeat");
    expect_int("idle_rbeat_busy", int'(busy_o), 0);

    // write len=3, reset held 3 cycles mid-burst
    step(0, 1, 1, 3, 0, "rst_mid");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, "rst_mid");
    step(1, 0, 0, 0, 0, "rst_mid");
    expect_int("rst_mid_oe", int'(oe_dqs_o | oe_db_o), 0);
    expect_int("rst_mid_pd", int'(pd_en_dqs_o & pd_en_db_o), 1);
    expect_int("rst_mid_busy", int'(busy_o), 0);
    step(1, 0, 0, 0, 0, "rst_mid");
    step(1, 0, 0, 0, 0, "rst_mid");
    step(0, 0, 0, 0, 0, "rst_mid");
    expect_int("rst_mid_ready", int'(req_ready_o), 1);

    // back-to-back write then read with valid held high
    step(0, 1, 1, 2, 0, "b2b");
    d1 = -1; d2 = -1; n_done = 0;
    for (int c = 1; c < 30 && n_done < 2; c++) begin
      if (done_o) begin
        n_done++;
        if (n_done == 1) d1 = c; else d2 = c;
      end
      if (n_done < 2) step(0, 1, 0, 1, 1, "b2b");
    end
    expect_int("b2b_write_done", d1, 8);
    expect_int("b2b_read_done", d2, 13);
    for (int i = 0; i < 20 && (busy_o || i == 0); i++) step(0, 0, 0, 0, 1, "b2b_drain");
    expect_int("b2b_drained", int'(busy_o), 0);

    // randomized traffic against the reference
    for (int i = 0; i < 2000; i++) begin
      step(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           ($urandom_range(0, 15) == 0) ? 255 : int'($urandom_range(0, 5)),
           $urandom_range(0, 9) < 6, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
